mux_tree_pipe: RTL and testbench

- Parametrised, pipelined N-to-1 multiplexer tree, the successor to the fixed mux2/4/8/16/32 family.
- Selects one DATA_W-bit lane out of N_IN lanes.
- Inserts a register stage after every LVL_PER_STG tree levels.
- Carries select and data through a valid/ready pipeline with full backpressure. Used wherever a wide, high-fan-in select would otherwise limit timing.

---
 rtl/mux_tree_pipe.sv | 161 ++++++++++++++++
 tb/tb_mux_tree_pipe.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN-to-1 lane multiplexer tree with a register stage after every LVL_PER_STG levels.
// Latency: NSTG cycles from acceptance to out_valid, 1 item/cycle sustained.
// Backpressure: full valid/ready; in_ready = ready chain from out_ready (the only comb path), capacity NSTG.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data/in_sel       N_IN lanes of DATA_W bits, lane index; sampled only on acceptance
//   in_valid/in_ready    input handshake
//   out_data/out_err     selected lane (0 when in_sel >= N_IN) and out-of-range flag
//   out_valid/out_ready  output handshake; out_data/out_err held while stalled
module mux_tree_pipe #(
    parameter int N_IN        = 32,
    parameter int DATA_W      = 1,
    parameter int LVL_PER_STG = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_IN*DATA_W-1:0]    in_data,
    input  logic [$clog2(N_IN)-1:0]   in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_err,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int SEL_W = $clog2(N_IN);
    localparam int NSTG  = (SEL_W + LVL_PER_STG - 1) / LVL_PER_STG;
    localparam int N_PAD = 1 << SEL_W;

    // First tree level handled by stage k (clamped so k = NSTG means "tree fully resolved").
    function automatic int lvl_lo(input int k);
        return (k * LVL_PER_STG < SEL_W) ? k * LVL_PER_STG : SEL_W;
    endfunction

    // Candidates entering stage k; entry NSTG is the single final lane.
    function automatic int n_cand(input int k);
        return 1 << (SEL_W - lvl_lo(k));
    endfunction

    function automatic int cand_off(input int k);
        int s = 0;
        for (int i = 0; i < k; i++) s += n_cand(i) * DATA_W;
        return s;
    endfunction

    function automatic int sel_off(input int k);
        int s = 0;
        for (int i = 0; i < k; i++) s += SEL_W - lvl_lo(i);
        return s;
    endfunction

    localparam int CAND_TOT = cand_off(NSTG + 1);
    localparam int SEL_TOT  = sel_off(NSTG);
    localparam logic [SEL_W:0] N_IN_V = (SEL_W + 1)'(N_IN);

    // Flat chains: slice k is what enters stage k; the last candidate slice is the output lane.
    wire  [CAND_TOT-1:0] cand_chain;
    wire  [SEL_TOT-1:0]  sel_chain;
    wire  [NSTG-1:0]     vld_w;
    wire  [NSTG-1:0]     err_w;
    logic [NSTG:0]       rdy_c;
    logic                in_err;

    assign cand_chain[N_IN*DATA_W-1:0] = in_data;
    assign sel_chain[SEL_W-1:0]        = in_sel;

    // Missing leaves read as zero, so an out-of-range select naturally yields zero data.
    if (N_PAD > N_IN) begin : g_pad
        assign cand_chain[N_PAD*DATA_W-1:N_IN*DATA_W] = '0;
    end

    assign in_err = ({1'b0, in_sel} >= N_IN_V);

    // Ready chain walks back from out_ready; kept in one block so it is a single comb net.
    always_comb begin
        rdy_c       = '0;
        rdy_c[NSTG] = out_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            rdy_c[k] = !vld_w[k] || rdy_c[k+1];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int LO  = lvl_lo(k);
        localparam int D   = lvl_lo(k + 1) - LO;
        localparam int NCI = n_cand(k);
        localparam int NCO = n_cand(k + 1);
        localparam int RSI = SEL_W - LO;
        localparam int RSO = RSI - D;

        wire  [NCI*DATA_W-1:0] cand_in = cand_chain[cand_off(k) +: NCI*DATA_W];
        wire  [RSI-1:0]        sel_in  = sel_chain[sel_off(k) +: RSI];
        wire                   up_vld;
        wire                   up_err;
        wire                   load;
        logic [NCO*DATA_W-1:0] cand_d;
        logic [NCO*DATA_W-1:0] cand_q;
        logic                  vld_q;
        logic                  err_q;

        if (k == 0) begin : g_first
            assign up_vld = in_valid;
            assign up_err = in_err;
        end else begin : g_next
            assign up_vld = vld_w[k-1];
            assign up_err = err_w[k-1];
        end

        assign load = rdy_c[k] && up_vld;

        // D tree levels at once: candidate j picks among its 2^D children with the low D select bits.
        always_comb begin
            cand_d = '0;
            for (int j = 0; j < NCO; j++) begin
                cand_d[j*DATA_W +: DATA_W] =
                    cand_in[(j * (1 << D) + int'(sel_in[D-1:0])) * DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                err_q <= 1'b0;
            end else begin
                if (rdy_c[k]) vld_q <= up_vld;
                if (load)     err_q <= up_err;
            end
        end

        if (k == NSTG - 1) begin : g_last
            // Final stage drives out_data directly, so it is cleared on reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    cand_q <= '0;
                else if (load) cand_q <= cand_d;
            end
        end else begin : g_mid
            logic [RSO-1:0] sel_q;

            always_ff @(posedge clk) begin
                if (load) begin
                    cand_q <= cand_d;
                    sel_q  <= sel_in[RSI-1:D];
                end
            end

            assign sel_chain[sel_off(k + 1) +: RSO] = sel_q;
        end

        assign cand_chain[cand_off(k + 1) +: NCO*DATA_W] = cand_q;
        assign vld_w[k] = vld_q;
        assign err_w[k] = err_q;
    end

    assign in_ready  = rdy_c[0];
    assign out_valid = vld_w[NSTG-1];
    assign out_err   = err_w[NSTG-1];
    assign out_data  = cand_chain[cand_off(NSTG) +: DATA_W];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe across four parameter sets sharing select/handshake stimulus.
// Directed sweeps, a vector table, multi-cycle corner sequences and a randomized queue model.
// Each DUT observes its own ready/valid; others idle harmlessly and are reset between sections.
module tb_mux_tree_pipe;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    sel8;
    logic          in_valid;
    logic          out_ready;
    logic [255:0]  data_a;
    logic [79:0]   data_b;
    logic [1:0]    data_c;
    logic [2047:0] data_d;

    logic       a_in_ready, a_out_err, a_out_valid;
    logic [7:0] a_out_data;
    logic       b_in_ready, b_out_err, b_out_valid;
    logic [3:0] b_out_data;
    logic       c_in_ready, c_out_err, c_out_valid;
    logic [0:0] c_out_data;
    logic       d_in_ready, d_out_err, d_out_valid;
    logic [7:0] d_out_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_tree_pipe #(.N_IN(32), .DATA_W(8), .LVL_PER_STG(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(data_a), .in_sel(sel8[4:0]),
        .in_valid(in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_err(a_out_err), .out_valid(a_out_valid), .out_ready(out_ready));

    mux_tree_pipe #(.N_IN(20), .DATA_W(4), .LVL_PER_STG(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(data_b), .in_sel(sel8[4:0]),
        .in_valid(in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_err(b_out_err), .out_valid(b_out_valid), .out_ready(out_ready));

    mux_tree_pipe #(.N_IN(2), .DATA_W(1), .LVL_PER_STG(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(data_c), .in_sel(sel8[0:0]),
        .in_valid(in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_err(c_out_err), .out_valid(c_out_valid), .out_ready(out_ready));

    mux_tree_pipe #(.N_IN(256), .DATA_W(8), .LVL_PER_STG(3)) u_d (
        .clk(clk), .rst_n(rst_n), .in_data(data_d), .in_sel(sel8),
        .in_valid(in_valid), .in_ready(d_in_ready), .out_data(d_out_data),
        .out_err(d_out_err), .out_valid(d_out_valid), .out_ready(out_ready));

    typedef struct {
        logic [7:0] sel;
        logic [3:0] dat;
        logic       err;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int n_of(input int idx);
        case (idx)
            0:       return 32;
            1:       return 20;
            2:       return 2;
            default: return 256;
        endcase
    endfunction

    function automatic int sw_of(input int idx);
        case (idx)
            0, 1:    return 5;
            2:       return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic rdy_of(input int idx);
        case (idx)
            0:       return a_in_ready;
            1:       return b_in_ready;
            2:       return c_in_ready;
            default: return d_in_ready;
        endcase
    endfunction

    function automatic logic vld_of(input int idx);
        case (idx)
            0:       return a_out_valid;
            1:       return b_out_valid;
            2:       return c_out_valid;
            default: return d_out_valid;
        endcase
    endfunction

    function automatic logic err_of(input int idx);
        case (idx)
            0:       return a_out_err;
            1:       return b_out_err;
            2:       return c_out_err;
            default: return d_out_err;
        endcase
    endfunction

    function automatic logic [7:0] dat_of(input int idx);
        case (idx)
            0:       return a_out_data;
            1:       return {4'h0, b_out_data};
            2:       return {7'h0, c_out_data};
            default: return d_out_data;
        endcase
    endfunction

    // Reference: the lane named by the select, or zero when the select names no lane.
    function automatic logic [7:0] ref_lane(input int idx, input int s);
        if (s >= n_of(idx)) return 8'h00;
        case (idx)
            0:       return data_a[s*8 +: 8];
            1:       return {4'h0, data_b[s*4 +: 4]};
            2:       return {7'h0, data_c[s]};
            default: return data_d[s*8 +: 8];
        endcase
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Returns the number of negedges until out_valid of DUT idx, or -1 if not within 8.
    task automatic wait_out(input int idx, output int lat);
        lat = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (vld_of(idx)) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic rand_run(input int idx, input int n_items, input string tag);
        logic [7:0] q_dat[$];
        logic       q_err[$];
        int         sent, got, cyc, s;
        logic       was_stalled;
        sent = 0; got = 0; cyc = 0; was_stalled = 1'b0;
        do_reset();
        while (got < n_items && cyc < n_items * 20) begin
            for (int i = 0; i < 8; i++)  data_a[i*32 +: 32] = $urandom;
            data_b = 80'({$urandom, $urandom, $urandom});
            data_c = 2'($urandom);
            for (int i = 0; i < 64; i++) data_d[i*32 +: 32] = $urandom;
            sel8      = 8'($urandom);
            in_valid  = (sent < n_items) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && rdy_of(idx)) begin
                s = int'(sel8) & ((1 << sw_of(idx)) - 1);
                q_dat.push_back(ref_lane(idx, s));
                q_err.push_back(s >= n_of(idx));
                sent++;
            end
            if (was_stalled) chk({tag, "_hold_vld"}, 32'(vld_of(idx)), 1);
            if (vld_of(idx)) begin
                if (q_dat.size() == 0) begin
                    chk({tag, "_spurious"}, 32'(q_dat.size()), 1);
                end else begin
                    chk({tag, "_dat"}, 32'(dat_of(idx)), 32'(q_dat[0]));
                    chk({tag, "_err"}, 32'(err_of(idx)), 32'(q_err[0]));
                    if (out_ready) begin
                        void'(q_dat.pop_front());
                        void'(q_err.pop_front());
                        got++;
                    end
                end
            end
            was_stalled = vld_of(idx) && !out_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_count"}, 32'(got), 32'(n_items));
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, want finish before 2ms");
        $fatal(1);
    end

    initial begin
        int         acc, rx, t_acc, t_out, lat, extra;
        logic [7:0] exp_q[$];
        logic [7:0] s_r;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel8 = '0;
        data_a = '0; data_b = '0; data_c = '0; data_d = '0;
        for (int i = 0; i < 32; i++) data_a[i*8 +: 8] = 8'(i + 'h40);
        for (int i = 0; i < 20; i++) data_b[i*4 +: 4] = 4'((i + 5) % 16);

        tbl[0] = '{8'd19, 4'h8, 1'b0};
        tbl[1] = '{8'd20, 4'h0, 1'b1};
        tbl[2] = '{8'd31, 4'h0, 1'b1};
        tbl[3] = '{8'd0,  4'h5, 1'b0};
        tbl[4] = '{8'd10, 4'hF, 1'b0};
        tbl[5] = '{8'd11, 4'h0, 1'b0};

        // Reset is asynchronous: outputs clear before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_out_data",  32'(a_out_data),  0);
        chk("rst_out_err",   32'(a_out_err),   0);
        chk("rst_in_ready",  32'(a_in_ready),  1);
        chk("rst_d_out_valid", 32'(d_out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back sweep of all 32 lanes.
        acc = 0; rx = 0; t_acc = -100; t_out = 0;
        for (int c = 0; c < 45; c++) begin
            in_valid = (c < 32);
            sel8     = 8'(c);
            @(negedge clk);
            if (in_valid) chk("sweep_in_ready", 32'(a_in_ready), 1);
            if (in_valid && a_in_ready) begin
                if (acc == 0) t_acc = c;
                acc++;
            end
            if (a_out_valid) begin
                if (rx == 0) t_out = c;
                chk("sweep_dat", 32'(a_out_data), 32'(rx + 'h40));
                chk("sweep_err", 32'(a_out_err), 0);
                rx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("sweep_count", 32'(rx), 32);
        chk("sweep_first_latency", 32'(t_out - t_acc), 3);

        // Range check on N_IN=20 via vector table.
        for (int v = 0; v < 6; v++) begin
            in_valid = 1'b1;
            sel8     = tbl[v].sel;
            @(negedge clk);
            chk("tbl_in_ready", 32'(b_in_ready), 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            wait_out(1, lat);
            chk("tbl_latency", 32'(lat), 3);
            chk("tbl_dat", 32'(b_out_data), 32'(tbl[v].dat));
            chk("tbl_err", 32'(b_out_err), 32'(tbl[v].err));
            @(posedge clk);
            #1;
        end

        // Backpressure: fill 3, stall, confirm hold, then drain in order.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            sel8     = (i == 0) ? 8'd5 : (i == 1) ? 8'd9 : 8'd17;
            @(negedge clk);
            chk("bp_fill_ready", 32'(a_in_ready), 1);
            @(posedge clk);
            #1;
        end
        sel8 = 8'd3;
        @(negedge clk);
        chk("bp_full_ready", 32'(a_in_ready), 0);
        chk("bp_full_valid", 32'(a_out_valid), 1);
        chk("bp_hold_dat",   32'(a_out_data), 'h45);
        @(posedge clk);
        #1;
        sel8 = 8'd20;
        @(negedge clk);
        chk("bp_full_ready2", 32'(a_in_ready), 0);
        chk("bp_hold_dat2",   32'(a_out_data), 'h45);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_drain_valid", 32'(a_out_valid), 1);
            chk("bp_drain_dat", 32'(a_out_data), (i == 0) ? 'h45 : (i == 1) ? 'h49 : 'h51);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("bp_empty", 32'(a_out_valid), 0);
        @(posedge clk);
        #1;

        // Full pipe, out_ready=1, new item every cycle: accept and emit together.
        do_reset();
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            s_r      = 8'($urandom_range(0, 31));
            sel8     = s_r;
            @(negedge clk);
            if (a_in_ready) exp_q.push_back(8'('h40 + s_r));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = (i < 10);
            s_r      = 8'($urandom_range(0, 31));
            sel8     = s_r;
            @(negedge clk);
            if (in_valid) begin
                chk("sim_in_ready", 32'(a_in_ready), 1);
                if (a_in_ready) exp_q.push_back(8'('h40 + s_r));
            end
            chk("sim_valid", 32'(a_out_valid), 1);
            if (exp_q.size() > 0) begin
                chk("sim_dat", 32'(a_out_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
        chk("sim_left", 32'(exp_q.size()), 0);

        // Reset mid-operation discards in-flight items asynchronously.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel8      = 8'd7;
        @(posedge clk);
        #1;
        sel8 = 8'd8;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_pre_valid", 32'(a_out_valid), 1);
        chk("mid_pre_dat",   32'(a_out_data), 'h47);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(a_out_valid), 0);
        chk("mid_rst_dat",   32'(a_out_data), 0);
        chk("mid_rst_err",   32'(a_out_err), 0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        sel8     = 8'd3;
        @(negedge clk);
        chk("mid_post_ready", 32'(a_in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(0, lat);
        chk("mid_post_latency", 32'(lat), 3);
        chk("mid_post_dat", 32'(a_out_data), 'h43);
        @(posedge clk);
        #1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_out_valid) extra++;
        end
        chk("mid_no_stale", 32'(extra), 0);
        @(posedge clk);
        #1;

        // Randomized runs against the queue model.
        rand_run(1, 300,  "rnd_n20");
        rand_run(2, 1000, "rnd_n2");
        rand_run(3, 1000, "rnd_n256");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
